mem_dados_p: RTL

MEM_DADOS_P -- requirements
Module: mem_dados_p

---
 rtl/mem_dados_p.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_dados_p.sv
// mem_dados_p: single-port word memory that zeroes itself after every reset.
// Accesses are accepted only once the clear sweep has finished (pronto = 1).
// Out-of-range accesses are dropped and raise a sticky erro flag.
// Reads are combinational (LEITURA_REG = 0) or registered read-first (LEITURA_REG = 1).
module mem_dados_p #(
  parameter int LARGURA      = 8,
  parameter int ENDERECO     = 8,
  parameter int PROFUNDIDADE = 16,
  parameter int LEITURA_REG  = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                write,
  input  logic                read,
  input  logic [LARGURA-1:0]  dadoEntrada,
  input  logic [ENDERECO-1:0] index,
  output logic [LARGURA-1:0]  dadoSaida,
  output logic                pronto,
  output logic                erro
);

  // Word-select width actually needed to address PROFUNDIDADE words.
  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  // Counter is one bit wider than the index so it can never wrap during the sweep.
  localparam logic [ENDERECO:0] LIMITE = (ENDERECO + 1)'(PROFUNDIDADE);
  localparam logic [ENDERECO:0] ULTIMO = (ENDERECO + 1)'(PROFUNDIDADE - 1);
  localparam logic [ENDERECO:0] UM     = (ENDERECO + 1)'(1);

  typedef enum logic [0:0] {
    LIMPA  = 1'b0,
    PRONTO = 1'b1
  } estado_t;

  estado_t             estado_r;
  estado_t             estado_s;
  logic [ENDERECO:0]   cnt_r;
  logic [LARGURA-1:0]  dado_r [PROFUNDIDADE];
  logic                erro_r;
  logic                em_faixa_s;
  logic                leitura_ok_s;
  logic [AW-1:0]       addr_s;
  logic [AW-1:0]       addr_limpa_s;
  logic [LARGURA-1:0]  dado_lido_s;

  // True when idx selects an existing word.
  function automatic logic na_faixa(input logic [ENDERECO-1:0] idx);
    return ({1'b0, idx} < LIMITE);
  endfunction

  assign em_faixa_s   = na_faixa(index);
  assign addr_s       = index[AW-1:0];
  assign addr_limpa_s = cnt_r[AW-1:0];
  assign pronto       = (estado_r == PRONTO);
  assign erro         = erro_r;

  // Read is qualified by ready and range; anything else returns zero.
  assign leitura_ok_s = read && (estado_r == PRONTO) && em_faixa_s;
  assign dado_lido_s  = leitura_ok_s ? dado_r[addr_s] : {LARGURA{1'b0}};

  // State register: reset forces the clear sweep to restart.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_r <= LIMPA;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Next state: leave LIMPA on the edge that clears the last word.
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      LIMPA: begin
        if (cnt_r == ULTIMO) begin
          estado_s = PRONTO;
        end else begin
          estado_s = LIMPA;
        end
      end
      PRONTO: begin
        estado_s = PRONTO;
      end
      default: begin
        estado_s = LIMPA;
      end
    endcase
  end

  // Clear pointer: advances once per edge while sweeping, then parks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {(ENDERECO + 1){1'b0}};
    end else if (estado_r == LIMPA) begin
      cnt_r <= cnt_r + UM;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Storage: zeroed by the sweep, then written only by in-range ready writes.
  always_ff @(posedge clock) begin
    if (estado_r == LIMPA) begin
      dado_r[addr_limpa_s] <= {LARGURA{1'b0}};
    end else if (write && em_faixa_s) begin
      dado_r[addr_s] <= dadoEntrada;
    end
  end

  // Sticky error: any ready access to a missing word sets it until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      erro_r <= 1'b0;
    end else if ((estado_r == PRONTO) && (write || read) && !em_faixa_s) begin
      erro_r <= 1'b1;
    end else begin
      erro_r <= erro_r;
    end
  end

  generate
    if (LEITURA_REG != 0) begin : g_leitura_reg
      logic [LARGURA-1:0] saida_r;

      // Registered read-first: captures the word as it was before this edge's write.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          saida_r <= {LARGURA{1'b0}};
        end else begin
          saida_r <= dado_lido_s;
        end
      end

      assign dadoSaida = saida_r;
    end else begin : g_leitura_comb
      assign dadoSaida = dado_lido_s;
    end
  endgenerate

endmodule
